seq_divider: RTL and testbench

SEQ_DIVIDER -- requirements
Module: seq_divider

---
 rtl/seq_divider.sv | 156 +++++++++++++++
 tb/tb_seq_divider.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/seq_divider.sv
// Sequential restoring divider: one quotient bit per clock, WIDTH+1 edges per result.
// Define SIGNED_DIV_EN for two's-complement operands (sign fix-up in FIX state).
module seq_divider #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] N,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Y,
  output logic [WIDTH-1:0] Z,
  output logic             busy,
  output logic             done,
  output logic             dz
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StRun, StFix, StDone} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]  rem_q, rem_d;
  logic [WIDTH-1:0]  quo_q, quo_d;
  logic [WIDTH-1:0]  div_q, div_d;
  logic [WIDTH-1:0]  y_q, y_d;
  logic [WIDTH-1:0]  z_q, z_d;
  logic              dz_q, dz_d;

  logic [WIDTH-1:0]  n_mag, b_mag;
  logic [WIDTH:0]    shifted;
  logic [WIDTH+1:0]  diff;
  logic              unused_top_bits;

`ifdef SIGNED_DIV_EN
  logic neg_q_q, neg_q_d;
  logic neg_r_q, neg_r_d;
  assign n_mag = N[WIDTH-1] ? (~N + 1'b1) : N;
  assign b_mag = B[WIDTH-1] ? (~B + 1'b1) : B;
`else
  assign n_mag = N;
  assign b_mag = B;
`endif

  // Extra headroom bit keeps the borrow intact when the divisor has its MSB set.
  assign shifted = {rem_q, quo_q[WIDTH-1]};
  assign diff    = {1'b0, shifted} - {2'b00, div_q};
  // Restore only happens when shifted < divisor, so shifted[WIDTH] is then zero.
  assign unused_top_bits = shifted[WIDTH] ^ diff[WIDTH];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    div_d   = div_q;
    y_d     = y_q;
    z_d     = z_q;
    dz_d    = dz_q;
`ifdef SIGNED_DIV_EN
    neg_q_d = neg_q_q;
    neg_r_d = neg_r_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (B == '0) begin
            y_d     = '1;
            z_d     = N;
            dz_d    = 1'b1;
            state_d = StDone;
          end else begin
            rem_d   = '0;
            quo_d   = n_mag;
            div_d   = b_mag;
            cnt_d   = '0;
            state_d = StRun;
`ifdef SIGNED_DIV_EN
            neg_q_d = N[WIDTH-1] ^ B[WIDTH-1];
            neg_r_d = N[WIDTH-1];
`endif
          end
        end
      end
      StRun: begin
        if (diff[WIDTH+1]) begin
          rem_d = shifted[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b0};
        end else begin
          rem_d = diff[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b1};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CntMax) begin
          state_d = StFix;
        end
      end
      StFix: begin
`ifdef SIGNED_DIV_EN
        y_d = neg_q_q ? (~quo_q + 1'b1) : quo_q;
        z_d = neg_r_q ? (~rem_q + 1'b1) : rem_q;
`else
        y_d = quo_q;
        z_d = rem_q;
`endif
        dz_d    = 1'b0;
        state_d = StDone;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      div_q   <= '0;
      y_q     <= '0;
      z_q     <= '0;
      dz_q    <= 1'b0;
`ifdef SIGNED_DIV_EN
      neg_q_q <= 1'b0;
      neg_r_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      div_q   <= div_d;
      y_q     <= y_d;
      z_q     <= z_d;
      dz_q    <= dz_d;
`ifdef SIGNED_DIV_EN
      neg_q_q <= neg_q_d;
      neg_r_q <= neg_r_d;
`endif
    end
  end

  assign busy = (state_q == StRun) || (state_q == StFix);
  assign done = (state_q == StDone);
  assign Y    = y_q;
  assign Z    = z_q;
  assign dz   = dz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider; define SIGNED_DIV_EN to exercise the signed build.
module tb_seq_divider;

  logic       clock;
  logic       reset_n;
  logic       start;
  logic [7:0] N;
  logic [7:0] B;
  logic [7:0] Y;
  logic [7:0] Z;
  logic       busy;
  logic       done;
  logic       dz;

  int n_checks = 0;
  int n_pass   = 0;

  seq_divider #(.WIDTH(8)) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .start  (start),
    .N      (N),
    .B      (B),
    .Y      (Y),
    .Z      (Z),
    .busy   (busy),
    .done   (done),
    .dz     (dz)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One start pulse, then wait (bounded) for done and check result and timing.
  task automatic run_op(input string tag, input logic [7:0] n, input logic [7:0] b,
                        input logic [7:0] ey, input logic [7:0] ez, input logic edz,
                        input int elat);
    int lat;
    int bsy;
    @(negedge clock);
    N = n;
    B = b;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    lat = 0;
    bsy = 0;
    while (!done && lat < 40) begin
      if (busy) bsy++;
      @(negedge clock);
      lat++;
    end
    check({tag, " latency"}, lat, elat);
    check({tag, " busy cycles"}, bsy, (elat == 0) ? 0 : 9);
    check({tag, " Y"}, Y, ey);
    check({tag, " Z"}, Z, ez);
    check({tag, " dz"}, dz, edz);
    @(negedge clock);
    check({tag, " done one cycle"}, done, 1'b0);
  endtask

  initial begin
    int nd;
    int d1;
    int d2;
    int cons;
    logic prev;
    logic [7:0] y1;
    logic [7:0] z1;
    logic [7:0] y2;
    logic [7:0] z2;

    reset_n = 1'b0;
    start   = 1'b0;
    N       = '0;
    B       = '0;
    #12;
    check("reset busy", busy, 1'b0);
    check("reset done", done, 1'b0);
    check("reset Y", Y, 8'h00);
    check("reset Z", Z, 8'h00);
    check("reset dz", dz, 1'b0);
    @(negedge clock);
    reset_n = 1'b1;

    run_op("100/7", 8'd100, 8'd7, 8'h0E, 8'h02, 1'b0, 9);
    run_op("55/0", 8'h55, 8'h00, 8'hFF, 8'h55, 1'b1, 0);
`ifdef SIGNED_DIV_EN
    run_op("-7/2", 8'hF9, 8'h02, 8'hFD, 8'hFF, 1'b0, 9);
    run_op("-128/-1", 8'h80, 8'hFF, 8'h80, 8'h00, 1'b0, 9);
    run_op("7/-2", 8'h07, 8'hFE, 8'hFD, 8'h01, 1'b0, 9);
`else
    run_op("FF/80", 8'hFF, 8'h80, 8'h01, 8'h7F, 1'b0, 9);
    run_op("5/9", 8'h05, 8'h09, 8'h00, 8'h05, 1'b0, 9);
    run_op("FE/FF", 8'hFE, 8'hFF, 8'h00, 8'hFE, 1'b0, 9);
`endif

    // start held high for 12 cycles; operands change mid-run.
    @(negedge clock);
    N = 8'hFF;
    B = 8'h01;
    start = 1'b1;
    nd = 0; d1 = 0; d2 = 0; cons = 0; prev = 1'b0;
    y1 = '0; z1 = '0; y2 = '0; z2 = '0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clock);
      if (done) begin
        if (nd == 0) begin
          d1 = i; y1 = Y; z1 = Z;
        end else if (nd == 1) begin
          d2 = i; y2 = Y; z2 = Z;
        end
        if (prev) cons++;
        nd++;
      end
      prev = done;
      if (i == 4) begin
        N = 8'h10;
        B = 8'h03;
      end
      if (i == 12) start = 1'b0;
    end
    check("held done count", nd, 2);
    check("held first done time", d1, 10);
    check("held first Y", y1, 8'hFF);
    check("held first Z", z1, 8'h00);
    check("held second done time", d2, 21);
    check("held second Y", y2, 8'h05);
    check("held second Z", z2, 8'h01);
    check("held back-to-back done", cons, 0);

    // Reset in the middle of RUN.
    @(negedge clock);
    N = 8'd200;
    B = 8'd9;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (4) @(posedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    check("abort busy", busy, 1'b0);
    check("abort done", done, 1'b0);
    check("abort Y", Y, 8'h00);
    check("abort Z", Z, 8'h00);
    check("abort dz", dz, 1'b0);
    @(negedge clock);
    reset_n = 1'b1;
    nd = 0;
    repeat (15) begin
      @(negedge clock);
      if (done) nd++;
    end
    check("abort no done", nd, 0);
`ifdef SIGNED_DIV_EN
    run_op("-56/9", 8'd200, 8'd9, 8'hFA, 8'hFE, 1'b0, 9);
`else
    run_op("200/9", 8'd200, 8'd9, 8'h16, 8'h02, 1'b0, 9);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
